// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational 32-bit ALU between N_REQ requesters.
//   Round-robin grant, valid/ready on both request and response sides, one
//   operation in flight, fixed IDLE -> EXEC -> RESP sequence.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake (ready one-hot)
//   req_a/req_b/req_aluc       packed per-requester operands and opcode
//   resp_valid/resp_ready      per-requester response handshake (valid one-hot)
//   resp_r/resp_flags/resp_err registered result, {zero,carry,neg,ovf,flag}, illegal-op
//   alu_a/alu_b/alu_aluc       drive the shared ALU
//   alu_r, alu_zero..alu_flag  ALU result and flags
//   busy, grant_id             state != IDLE, current/last granted requester
module alu_share_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDW   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [6*N_REQ-1:0]   req_aluc,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [31:0]          resp_r,
  output logic [4:0]           resp_flags,
  output logic                 resp_err,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [5:0]           alu_aluc,
  input  logic [31:0]          alu_r,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_negative,
  input  logic                 alu_overflow,
  input  logic                 alu_flag,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int unsigned NR = N_REQ;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    gid_q, gid_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [5:0]        aluc_q, aluc_d;
  logic [31:0]       r_q, r_d;
  logic [4:0]        flags_q, flags_d;
  logic              err_q, err_d;

  logic              found;
  logic [IDW-1:0]    pick;
  logic [N_REQ-1:0]  pick_oh, gid_oh;
  logic [31:0]       sel_a, sel_b;
  logic [5:0]        sel_aluc;
  logic              rdy_sel;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011,
      6'b000000, 6'b000010, 6'b000011,
      6'b000100, 6'b000110, 6'b000111,
      6'b001111: is_legal = 1'b1;
      default:   is_legal = 1'b0;
    endcase
  endfunction

  // Round-robin search: indices at/above rr_q first, then wrap to those below.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (!found && j >= 32'(rr_q) && req_valid[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
    for (int unsigned j = 0; j < NR; j++) begin
      if (!found && j < 32'(rr_q) && req_valid[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
  end

  // Operand mux and one-hot decodes for the picked and the granted requester.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_aluc = '0;
    pick_oh  = '0;
    gid_oh   = '0;
    rdy_sel  = 1'b0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (32'(pick) == j) begin
        sel_a      = req_a[32*j +: 32];
        sel_b      = req_b[32*j +: 32];
        sel_aluc   = req_aluc[6*j +: 6];
        pick_oh[j] = 1'b1;
      end
      if (32'(gid_q) == j) begin
        gid_oh[j] = 1'b1;
        rdy_sel   = resp_ready[j];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gid_d      = gid_q;
    a_d        = a_q;
    b_d        = b_q;
    aluc_d     = aluc_q;
    r_d        = r_q;
    flags_d    = flags_q;
    err_d      = err_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no request is acknowledged while reset is held.
        if (found && rst_n) begin
          req_ready = pick_oh;
          a_d       = sel_a;
          b_d       = sel_b;
          aluc_d    = sel_aluc;
          gid_d     = pick;
          rr_d      = (32'(pick) == NR - 1) ? '0 : pick + 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_legal(aluc_q)) begin
          err_d   = 1'b0;
          r_d     = alu_r;
          flags_d = {alu_zero, alu_carry, alu_negative, alu_overflow,
                     alu_flag & ((aluc_q == OP_SLT) || (aluc_q == OP_SLTU))};
        end else begin
          err_d   = 1'b1;
          r_d     = '0;
          flags_d = '0;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = gid_oh;
        if (rdy_sel) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= OP_AND;
      r_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      r_q     <= r_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_aluc   = aluc_q;
  assign resp_r     = r_q;
  assign resp_flags = flags_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with N_REQ=2: behavioural ALU, directed ops,
// scoreboard queue filled at accept and drained by an independent monitor.
module tb_alu_share_arbiter;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, OR_ = 6'b100101,
                         XOR = 6'b100110, SLT = 6'b101010, SLTU = 6'b101011,
                         AND = 6'b100100, BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [63:0] req_a, req_b;
  logic [11:0] req_aluc;
  logic [31:0] resp_r, alu_a, alu_b, alu_r;
  logic [4:0]  resp_flags;
  logic        resp_err, busy, grant_id;
  logic [5:0]  alu_aluc;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow, alu_flag;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_REQ(2), .IDW(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_aluc(req_aluc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_r(resp_r), .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .alu_flag(alu_flag),
    .busy(busy), .grant_id(grant_id)
  );

  // Behavioural ALU. flag is driven high for non-compare ops so that the
  // arbiter's masking is observable; unknown codes return a garbage value.
  always_comb begin
    alu_r        = 32'hDEADBEEF;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_flag     = 1'b1;
    case (alu_aluc)
      6'b100000, 6'b100001: begin
        {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      6'b100010, 6'b100011: begin
        alu_r        = alu_a - alu_b;
        alu_carry    = alu_a < alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      6'b100100: alu_r = alu_a & alu_b;
      6'b100101: alu_r = alu_a | alu_b;
      6'b100110: alu_r = alu_a ^ alu_b;
      6'b100111: alu_r = ~(alu_a | alu_b);
      6'b101010: begin
        alu_r    = {31'b0, $signed(alu_a) < $signed(alu_b)};
        alu_flag = alu_r[0];
      end
      6'b101011: begin
        alu_r    = {31'b0, alu_a < alu_b};
        alu_flag = alu_r[0];
      end
      default: ;
    endcase
    alu_zero     = (alu_r == 32'b0);
    alu_negative = alu_r[31];
  end

  typedef struct {
    int          id;
    logic [31:0] r;
    logic [4:0]  f;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [31:0] r, input logic [4:0] f, input logic e);
    exp_t x;
    x.id = id; x.r = r; x.f = f; x.e = e;
    q.push_back(x);
  endtask

  // Monitor: compares once per response, on the first cycle resp_valid is seen.
  initial begin : mon
    bit   seen;
    exp_t x;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid == 2'b00) seen = 1'b0;
      else if (!seen) begin
        seen = 1'b1;
        if (q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
        else begin
          x = q.pop_front();
          chk("resp_valid_onehot", 32'(resp_valid), 32'(1) << x.id);
          chk("resp_grant_id", 32'(grant_id), 32'(x.id));
          chk("resp_r", resp_r, x.r);
          chk("resp_flags", 32'(resp_flags), 32'(x.f));
          chk("resp_err", 32'(resp_err), 32'(x.e));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_r"}, resp_r, 32'd0);
    chk({tag, "_resp_flags"}, 32'(resp_flags), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_alu_aluc"}, 32'(alu_aluc), 32'(AND));
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input int id);
    int k;
    k = 0;
    #1;
    while (!req_ready[id] && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("accept", 32'(req_ready), 32'(1) << id);
  endtask

  // One op with resp_ready high: checks same-cycle ready and 2-cycle latency,
  // and scrambles the operands after accept to show they were latched.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op, input logic [31:0] er,
                       input logic [4:0] ef, input logic ee);
    @(negedge clk);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_aluc[6*id +: 6] = op;
    req_valid[id] = 1'b1;
    wait_accept(id);
    push(id, er, ef, ee);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    req_a[32*id +: 32] = 32'h12345678;
    req_aluc[6*id +: 6] = BAD;
    @(negedge clk);
    chk("lat_exec_no_valid", 32'(resp_valid), 32'd0);
    chk("lat_exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_resp_valid", 32'(resp_valid), 32'(1) << id);
    @(posedge clk);
  endtask

  initial begin : stim
    int grants;
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_aluc = '0;
    resp_ready = 2'b11;
    do_reset();

    // Basic ADD, flag masked.
    do_op(0, 32'd5, 32'd3, ADD, 32'd8, 5'b00000, 1'b0);

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    do_reset();
    @(negedge clk);
    req_a = {32'hF0F0F0F0, 32'd1};
    req_b = {32'h0F0F0F0F, 32'd1};
    req_aluc = {XOR, ADD};
    req_valid = 2'b11;
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_grant", 32'(req_ready), (grants % 2 == 0) ? 32'd1 : 32'd2);
        if (grants % 2 == 0) push(0, 32'd2, 5'b00000, 1'b0);
        else                 push(1, 32'hFFFFFFFF, 5'b00100, 1'b0);
        grants++;
      end
      if (grants < 4) @(negedge clk);
    end
    chk("rr_grant_count", 32'(grants), 32'd4);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Signed vs unsigned compare.
    do_op(1, 32'hFFFFFFFF, 32'd1, SLT,  32'd1, 5'b00001, 1'b0);
    do_op(1, 32'hFFFFFFFF, 32'd1, SLTU, 32'd0, 5'b10000, 1'b0);

    // Illegal opcode, then a legal one clears the error.
    do_op(0, 32'd12, 32'd34, BAD, 32'd0, 5'b00000, 1'b1);
    do_op(0, 32'd7,  32'd7,  SUB, 32'd0, 5'b10000, 1'b0);

    // Response stall on requester 0 while requester 1 waits.
    @(negedge clk);
    resp_ready = 2'b10;
    req_a[31:0] = 32'd10; req_b[31:0] = 32'd20; req_aluc[5:0] = ADD;
    req_valid[0] = 1'b1;
    wait_accept(0);
    push(0, 32'd30, 5'b00000, 1'b0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_a[63:32] = 32'h0000000F; req_b[63:32] = 32'h000000F0; req_aluc[11:6] = OR_;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5 && resp_valid[0] !== 1'b1; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("stall_resp_r", resp_r, 32'd30);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 2'b11;
    @(negedge clk);
    #1;
    chk("pending_accept", 32'(req_ready), 32'd2);
    push(1, 32'h000000FF, 5'b00000, 1'b0);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Reset during EXEC discards the op.
    req_a[31:0] = 32'd1; req_b[31:0] = 32'd2; req_aluc[5:0] = ADD;
    req_valid[0] = 1'b1;
    wait_accept(0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_reset("mid_exec");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_resp_after_reset", 32'(resp_valid), 32'd0);
    end

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
